// File: rtl/display_value_formatter.sv
// Formats a 20-bit value as six digit codes plus a leading-zero blank mask.
// Decimal mode uses a serial double-dabble (one shift per clock), hex mode is a direct split.
module display_value_formatter #(
  parameter int BLANK_LZ = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] value,
  input  logic        hex_mode,
  input  logic        load,
  output logic        ready,
  output logic        done,
  output logic [3:0]  BCH5,
  output logic [3:0]  BCH4,
  output logic [3:0]  BCH3,
  output logic [3:0]  BCH2,
  output logic [3:0]  BCH1,
  output logic [3:0]  BCH0,
  output logic [5:0]  blank
);

  localparam logic [5:0]  BLANK_RESET = (BLANK_LZ != 0) ? 6'b111110 : 6'b000000;
  localparam logic [19:0] DEC_MAX     = 20'd999999;
  localparam logic [4:0]  LAST_SHIFT  = 5'd19;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    UPDATE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [43:0] shreg;
  logic [43:0] shreg_adj;
  logic [4:0]  shift_cnt;
  logic        hex_q;
  logic        ovf_q;
  logic [23:0] digits;
  logic [5:0]  blank_next;
  logic        zero_run;

  assign ready = (state == IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = (hex_mode || (value > DEC_MAX)) ? UPDATE : CONV;
        end
      end
      CONV: begin
        if (shift_cnt == LAST_SHIFT) begin
          state_next = UPDATE;
        end
      end
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    shreg_adj = shreg;
    for (int i = 0; i < 6; i++) begin
      if (shreg[20 + 4*i +: 4] >= 4'd5) begin
        shreg_adj[20 + 4*i +: 4] = shreg[20 + 4*i +: 4] + 4'd3;
      end
    end
  end

  // The raw value stays in the low 20 bits in hex/overflow mode since no shifts happen there.
  always_comb begin
    digits     = shreg[43:20];
    blank_next = 6'b000000;
    zero_run   = 1'b1;
    if (ovf_q) begin
      digits = 24'hEEEEEE;
    end else if (hex_q) begin
      digits = {4'h0, shreg[19:0]};
    end
    for (int i = 5; i >= 1; i--) begin
      zero_run      = zero_run && (digits[4*i +: 4] == 4'h0);
      blank_next[i] = zero_run;
    end
    if ((BLANK_LZ == 0) || ovf_q) begin
      blank_next = 6'b000000;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      shift_cnt <= '0;
      hex_q     <= 1'b0;
      ovf_q     <= 1'b0;
      done      <= 1'b0;
      BCH5      <= 4'h0;
      BCH4      <= 4'h0;
      BCH3      <= 4'h0;
      BCH2      <= 4'h0;
      BCH1      <= 4'h0;
      BCH0      <= 4'h0;
      blank     <= BLANK_RESET;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg     <= {24'b0, value};
            shift_cnt <= '0;
            hex_q     <= hex_mode;
            ovf_q     <= !hex_mode && (value > DEC_MAX);
          end
        end
        CONV: begin
          shreg     <= shreg_adj << 1;
          shift_cnt <= shift_cnt + 5'd1;
        end
        UPDATE: begin
          BCH5  <= digits[23:20];
          BCH4  <= digits[19:16];
          BCH3  <= digits[15:12];
          BCH2  <= digits[11:8];
          BCH1  <= digits[7:4];
          BCH0  <= digits[3:0];
          blank <= blank_next;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_value_formatter.sv
// Self-checking bench for display_value_formatter: vector table plus scoreboard of
// expected results, with hand-written sequences for busy-load, reset abort and held load.
module tb_display_value_formatter;

  typedef struct {
    logic [19:0] value;
    logic        hex;
    logic [23:0] digits;
    logic [5:0]  blank;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [23:0] digits;
    logic [5:0]  blank;
    int          lat;
    int          acc;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [19:0] value;
  logic        hex_mode;
  logic        load;
  logic        ready;
  logic        done;
  logic [3:0]  BCH5, BCH4, BCH3, BCH2, BCH1, BCH0;
  logic [5:0]  blank;
  logic [23:0] dut_digits;

  int   cyc;
  int   passed;
  int   total;
  int   done_count;
  int   exp_dones;
  logic [23:0] last_digits;
  logic [5:0]  last_blank;
  exp_t sb[$];
  vec_t tbl[12];

  display_value_formatter #(.BLANK_LZ(1)) dut (
    .clock   (clock),
    .reset   (reset),
    .value   (value),
    .hex_mode(hex_mode),
    .load    (load),
    .ready   (ready),
    .done    (done),
    .BCH5    (BCH5),
    .BCH4    (BCH4),
    .BCH3    (BCH3),
    .BCH2    (BCH2),
    .BCH1    (BCH1),
    .BCH0    (BCH0),
    .blank   (blank)
  );

  assign dut_digits = {BCH5, BCH4, BCH3, BCH2, BCH1, BCH0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Reference model: decimal digits by repeated division, blanking from the top digit down.
  function automatic exp_t model(input string name, input logic [19:0] v, input logic hex, input int lat);
    exp_t e;
    int   t;
    logic z;
    e.name   = name;
    e.digits = '0;
    e.blank  = '0;
    e.lat    = lat;
    e.acc    = 0;
    if (hex) begin
      e.digits = {4'h0, v};
    end else if (v > 20'd999999) begin
      e.digits = 24'hEEEEEE;
    end else begin
      t = int'(v);
      for (int i = 0; i < 6; i++) begin
        e.digits[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    if (hex || v <= 20'd999999) begin
      z = 1'b1;
      for (int i = 5; i >= 1; i--) begin
        z = z && (e.digits[4*i +: 4] == 4'h0);
        e.blank[i] = z;
      end
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      done_count++;
      if (sb.size() == 0) begin
        total++;
        $display("[TB] FAIL unexpected_done: done=1, required 0");
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_digits"}, 32'(dut_digits), 32'(e.digits));
        checkOutput({e.name, "_blank"}, 32'(blank), 32'(e.blank));
        checkOutput({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
        last_digits = e.digits;
        last_blank  = e.blank;
      end
    end
  end

  task automatic waitReady(input string name);
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!ready) checkOutput({name, "_ready_timeout"}, 32'(ready), 32'd1);
  endtask

  task automatic applyStimulus(input string name, input logic [19:0] v, input logic hex,
                               input logic [23:0] exp_digits, input logic [5:0] exp_blank,
                               input int lat);
    exp_t e;
    waitReady(name);
    value    = v;
    hex_mode = hex;
    load     = 1'b1;
    e.name   = name;
    e.digits = exp_digits;
    e.blank  = exp_blank;
    e.lat    = lat;
    e.acc    = cyc + 1;
    sb.push_back(e);
    exp_dones++;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    exp_t h;
    int   dc;
    logic [19:0] rv;

    passed = 0; total = 0; done_count = 0; exp_dones = 0;
    last_digits = '0; last_blank = 6'b111110;
    reset = 1'b1; load = 1'b0; value = '0; hex_mode = 1'b0;

    tbl[0]  = '{20'd123456,  1'b0, 24'h123456, 6'b000000, 21};
    tbl[1]  = '{20'd42,      1'b0, 24'h000042, 6'b111100, 21};
    tbl[2]  = '{20'd0,       1'b0, 24'h000000, 6'b111110, 21};
    tbl[3]  = '{20'd999999,  1'b0, 24'h999999, 6'b000000, 21};
    tbl[4]  = '{20'hABCDE,   1'b1, 24'h0ABCDE, 6'b100000, 1};
    tbl[5]  = '{20'd1000000, 1'b0, 24'hEEEEEE, 6'b000000, 1};
    tbl[6]  = '{20'hFFFFF,   1'b0, 24'hEEEEEE, 6'b000000, 1};
    tbl[7]  = '{20'd100000,  1'b0, 24'h100000, 6'b000000, 21};
    tbl[8]  = '{20'h00000,   1'b1, 24'h000000, 6'b111110, 1};
    tbl[9]  = '{20'hFFFFF,   1'b1, 24'h0FFFFF, 6'b100000, 1};
    tbl[10] = '{20'd10,      1'b0, 24'h000010, 6'b111100, 21};
    tbl[11] = '{20'h00100,   1'b1, 24'h000100, 6'b111000, 1};

    repeat (2) @(negedge clock);
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_digits", 32'(dut_digits), 32'd0);
    checkOutput("reset_blank", 32'(blank), 32'(6'b111110));
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 12; i++) begin
      applyStimulus($sformatf("vec%0d", i), tbl[i].value, tbl[i].hex,
                    tbl[i].digits, tbl[i].blank, tbl[i].lat);
      waitDrain($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      case (i % 3)
        0: begin rv = 20'($urandom_range(0, 999999));        e = model($sformatf("rnd%0d", i), rv, 1'b0, 21); end
        1: begin rv = 20'($urandom_range(0, 20'hFFFFF));     e = model($sformatf("rnd%0d", i), rv, 1'b1, 1);  end
        default: begin rv = 20'($urandom_range(0, 9999));   e = model($sformatf("rnd%0d", i), rv, 1'b0, 21); end
      endcase
      applyStimulus(e.name, rv, (i % 3) == 1, e.digits, e.blank, e.lat);
      waitDrain(e.name);
    end

    // Busy load: a second request mid-conversion must be dropped, inputs may wander.
    dc = done_count;
    applyStimulus("busy500", 20'd500, 1'b0, 24'h000500, 6'b111000, 21);
    checkOutput("hold_digits", 32'(dut_digits), 32'(last_digits));
    checkOutput("hold_blank", 32'(blank), 32'(last_blank));
    checkOutput("busy_ready", 32'(ready), 32'd0);
    repeat (3) @(negedge clock);
    value = 20'd7; hex_mode = 1'b1; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    waitDrain("busy500");
    repeat (25) @(negedge clock);
    checkOutput("busy_single_done", 32'(done_count - dc), 32'd1);

    // Reset in the 10th conversion cycle aborts without a done pulse.
    applyStimulus("abort123", 20'd123, 1'b0, 24'h000123, 6'b111000, 21);
    repeat (9) @(negedge clock);
    dc = done_count;
    reset = 1'b1;
    sb.delete();
    exp_dones--;
    #1;
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_digits", 32'(dut_digits), 32'd0);
    checkOutput("abort_blank", 32'(blank), 32'(6'b111110));
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (25) @(negedge clock);
    checkOutput("abort_no_done", 32'(done_count - dc), 32'd0);
    applyStimulus("after88", 20'd88, 1'b0, 24'h000088, 6'b111100, 21);
    waitDrain("after88");

    // Held load in hex mode is re-accepted every other cycle.
    waitReady("held");
    value = 20'h12345; hex_mode = 1'b1; load = 1'b1;
    for (int k = 0; k < 3; k++) begin
      h = model($sformatf("held%0d", k), 20'h12345, 1'b1, 1);
      h.acc = cyc + 1 + 2*k;
      sb.push_back(h);
      exp_dones++;
    end
    repeat (5) @(negedge clock);
    load = 1'b0;
    waitDrain("held");
    repeat (5) @(negedge clock);

    checkOutput("done_count", 32'(done_count), 32'(exp_dones));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
